// File: rtl/retire_buffer_pkg.sv
// Shared sizing, tag and payload types for the in-order retire buffer.
package retire_buffer_pkg;
    localparam int RENAME_WIDTH = 4;
    localparam int COMMIT_WIDTH = 4;
    localparam int WB_WIDTH     = 4;
    localparam int DEPTH        = 32;
    localparam int PRF_IDX_W    = 6;
    localparam int TAG_W        = $clog2(DEPTH);
    localparam int K_W          = $clog2(COMMIT_WIDTH + 1);

    // Pointer with wrap bit on top; rb_idx_t is the slot index without it.
    typedef logic [TAG_W:0]   rb_tag_t;
    typedef logic [TAG_W-1:0] rb_idx_t;

    typedef struct packed {
        logic                 prev_rd_valid;
        logic [PRF_IDX_W-1:0] prev_rd;
    } rb_payload_t;
endpackage

// File: rtl/retire_buffer_if.sv
// Rename/execute/free-list side signals of the retire buffer, bundled with master/slave views.
interface retire_buffer_if;
    import retire_buffer_pkg::*;

    logic                              stall;
    logic [RENAME_WIDTH-1:0]           enq_valid;
    logic [RENAME_WIDTH*PRF_IDX_W-1:0] enq_prev_rd;
    logic [RENAME_WIDTH-1:0]           enq_prev_rd_valid;
    logic                              enq_ready;
    logic [RENAME_WIDTH*TAG_W-1:0]     enq_tag;
    logic [WB_WIDTH-1:0]               wb_valid;
    logic [WB_WIDTH*TAG_W-1:0]         wb_tag;
    logic                              recover;
    logic [TAG_W-1:0]                  recover_tag;
    logic [COMMIT_WIDTH-1:0]           retire_req;
    logic [COMMIT_WIDTH*PRF_IDX_W-1:0] retire_prf;
    logic                              empty;

    modport master (
        output stall, enq_valid, enq_prev_rd, enq_prev_rd_valid, wb_valid, wb_tag,
               recover, recover_tag,
        input  enq_ready, enq_tag, retire_req, retire_prf, empty
    );

    modport slave (
        input  stall, enq_valid, enq_prev_rd, enq_prev_rd_valid, wb_valid, wb_tag,
               recover, recover_tag,
        output enq_ready, enq_tag, retire_req, retire_prf, empty
    );
endinterface

// File: rtl/retire_buffer_select.sv
// Leading-run finder: counts consecutive ready slots starting at head, capped at COMMIT_WIDTH.
module retire_buffer_select
    import retire_buffer_pkg::*;
(
    input  logic [DEPTH-1:0] i_ready,
    input  rb_idx_t          i_head,
    output logic [K_W-1:0]   o_num,
    output rb_idx_t          o_idx [COMMIT_WIDTH]
);
    logic w_run;

    // NOTE: combinational logic uses blocking assignments with a default first, so the
    // running value chains lane to lane and no latch is inferred.
    always_comb begin
        o_num = '0;
        w_run = 1'b1;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            o_idx[i] = i_head + rb_idx_t'(i);
            w_run    = w_run & i_ready[o_idx[i]];
            if (w_run) o_num = o_num + K_W'(1);
        end
    end
endmodule

// File: rtl/retire_buffer.sv
// In-order retire buffer feeding released registers back to the rename free list.
// Optional RETIRE_BUFFER_PERF_EN adds saturating retired-entry and full-cycle counters.
module retire_buffer
    import retire_buffer_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef RETIRE_BUFFER_PERF_EN
    output logic [31:0] o_perf_retired,
    output logic [31:0] o_perf_full_cycles,
`endif
    retire_buffer_if.slave bus
);
    rb_tag_t                           r_head, r_tail;
    logic [DEPTH-1:0]                  r_valid, r_done;
    rb_payload_t                       r_payload [DEPTH];
    logic [COMMIT_WIDTH-1:0]           r_retire_req;
    logic [COMMIT_WIDTH*PRF_IDX_W-1:0] r_retire_prf;

    rb_tag_t                       w_count;
    logic                          w_enq_ready, w_enq_fire;
    rb_idx_t                       w_enq_idx [RENAME_WIDTH];
    rb_idx_t                       w_enq_num;
    logic [RENAME_WIDTH*TAG_W-1:0] w_enq_tag;
    logic [K_W-1:0]                w_ret_num;
    rb_idx_t                       w_ret_idx [COMMIT_WIDTH];
    logic [DEPTH-1:0]              w_ret_mask, w_drop_mask, w_valid_nxt, w_done_nxt;
    rb_idx_t                       w_rec_ofs;
    rb_tag_t                       w_rec_tail;

    assign w_count     = r_tail - r_head;
    assign w_enq_ready = (w_count <= rb_tag_t'(DEPTH - RENAME_WIDTH));
    assign w_enq_fire  = w_enq_ready & ~bus.stall & ~bus.recover & (|bus.enq_valid);

    // Valid lanes pack densely from tail in lane order.
    always_comb begin
        w_enq_num = '0;
        w_enq_tag = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            w_enq_idx[i]                = r_tail[TAG_W-1:0] + w_enq_num;
            w_enq_tag[i*TAG_W +: TAG_W] = w_enq_idx[i];
            w_enq_num                   = w_enq_num + rb_idx_t'(bus.enq_valid[i]);
        end
    end

    retire_buffer_select u_select (
        .i_ready (r_valid & r_done),
        .i_head  (r_head[TAG_W-1:0]),
        .o_num   (w_ret_num),
        .o_idx   (w_ret_idx)
    );

    // Branch offset from head rebuilds tail with a wrap bit consistent with head.
    assign w_rec_ofs  = bus.recover_tag - r_head[TAG_W-1:0];
    assign w_rec_tail = r_head + rb_tag_t'(w_rec_ofs) + rb_tag_t'(1);

    always_comb begin
        w_ret_mask  = '0;
        w_drop_mask = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++)
            if (K_W'(i) < w_ret_num) w_ret_mask[w_ret_idx[i]] = 1'b1;
        for (int j = 0; j < DEPTH; j++)
            w_drop_mask[j] = bus.recover &&
                (rb_idx_t'(rb_idx_t'(j) - r_head[TAG_W-1:0]) > w_rec_ofs);

        w_valid_nxt = r_valid & ~w_ret_mask;
        w_done_nxt  = r_done  & ~w_ret_mask;
        for (int i = 0; i < WB_WIDTH; i++)
            if (bus.wb_valid[i] && w_valid_nxt[bus.wb_tag[i*TAG_W +: TAG_W]])
                w_done_nxt[bus.wb_tag[i*TAG_W +: TAG_W]] = 1'b1;
        if (w_enq_fire)
            for (int i = 0; i < RENAME_WIDTH; i++)
                if (bus.enq_valid[i]) begin
                    w_valid_nxt[w_enq_idx[i]] = 1'b1;
                    w_done_nxt[w_enq_idx[i]]  = 1'b0;
                end
        // Drop is applied last so it overrides a same-cycle completion.
        w_valid_nxt = w_valid_nxt & ~w_drop_mask;
        w_done_nxt  = w_done_nxt  & ~w_drop_mask;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_valid      <= '0;
            r_done       <= '0;
            r_retire_req <= '0;
            r_retire_prf <= '0;
        end else begin
            r_head <= r_head + rb_tag_t'(w_ret_num);
            if (bus.recover)     r_tail <= w_rec_tail;
            else if (w_enq_fire) r_tail <= r_tail + rb_tag_t'(w_enq_num);
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (K_W'(i) < w_ret_num) begin
                    r_retire_req[i]                          <= r_payload[w_ret_idx[i]].prev_rd_valid;
                    r_retire_prf[i*PRF_IDX_W +: PRF_IDX_W] <= r_payload[w_ret_idx[i]].prev_rd;
                end else begin
                    r_retire_req[i]                          <= 1'b0;
                    r_retire_prf[i*PRF_IDX_W +: PRF_IDX_W] <= '0;
                end
            end
        end
    end

    // NOTE: payload storage has no reset; valid/done gate every read, so it maps to plain RAM.
    always_ff @(posedge clk) begin
        if (w_enq_fire)
            for (int i = 0; i < RENAME_WIDTH; i++)
                if (bus.enq_valid[i])
                    r_payload[w_enq_idx[i]] <= '{
                        prev_rd_valid: bus.enq_prev_rd_valid[i],
                        prev_rd:       bus.enq_prev_rd[i*PRF_IDX_W +: PRF_IDX_W]
                    };
    end

    assign bus.enq_ready  = w_enq_ready;
    assign bus.enq_tag    = w_enq_tag;
    assign bus.retire_req = r_retire_req;
    assign bus.retire_prf = r_retire_prf;
    assign bus.empty      = (w_count == '0);

`ifdef RETIRE_BUFFER_PERF_EN
    logic [31:0] r_perf_retired, r_perf_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_retired <= '0;
            r_perf_full    <= '0;
        end else begin
            if (r_perf_retired <= 32'hFFFF_FFFF - 32'(w_ret_num))
                r_perf_retired <= r_perf_retired + 32'(w_ret_num);
            else
                r_perf_retired <= '1;
            if (!w_enq_ready && (|bus.enq_valid) && (r_perf_full != '1))
                r_perf_full <= r_perf_full + 32'd1;
        end
    end

    assign o_perf_retired     = r_perf_retired;
    assign o_perf_full_cycles = r_perf_full;
`endif
endmodule
